filtro_pb_stream: RTL and testbench
===================================

Name: filtro_pb_stream

Overview:
Streaming, multi-channel successor to the one-shot sort-and-count low-pass filter. It takes one oversampled bit per channel per enabled clock into a sliding window of SAMPLES*OSF bits. It keeps a running ones-count per channel and produces a hysteretic, debounced decision bit per channel. It sits between the oversampling front end and the symbol/edge logic, and replaces the full-vector sort+sum path with O(1) update logic per sample.

Parameters:
SAMPLES, 128, samples per symbol window
OSF, 8, oversampling factor; WINDOW = SAMPLES*OSF bits per channel
CHANNELS, 1, independent filter channels
THR_HI, (SAMPLES*OSF*3)/4, count at or above which the decision is set to 1
THR_LO, (SAMPLES*OSF)/4, count at or below which the decision is cleared to 0; must satisfy THR_LO < THR_HI <= WINDOW

Ports:
P  input  1  clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Enable  input  1  sample strobe; one new bit per channel is accepted when high
Clear  input  1  synchronous window restart, same effect as Reset on datapath state
DataIn  input  CHANNELS  new oversampled bit, bit c belongs to channel c
DataOut  output  CHANNELS*($clog2(SAMPLES*OSF)+1)  per-channel ones count; channel c occupies slice [c*CW +: CW], where CW = $clog2(SAMPLES*OSF)+1
Decision  output  CHANNELS  hysteretic filtered level per channel
Valid  output  1  high once the window is fully populated

Behaviour:
- Clock and reset: one clock P; Reset is synchronous and active-high.
- Reset values: all window bits 0, every DataOut slice 0, Decision 0, Valid 0, fill counter 0, state FILL.
- Window per channel: WINDOW-bit shift register. On each Enable cycle the new bit shifts in at the head and the oldest bit drops off.
- Count update, per channel, registered: cnt <= cnt + DataIn[c] - oldest[c]. The result is visible on DataOut one cycle after the Enable edge, so latency is 1 clock.
  - cnt range is 0..WINDOW inclusive.
  - CW bits are sufficient, so no saturation is needed.
  - The arithmetic is unsigned. cnt=WINDOW with in=1/old=1 must hold WINDOW; cnt=0 with in=0/old=0 must hold 0.
- Enable=0: window, counts, Decision and the fill counter all hold.
- FSM, shared by all channels:
  - FILL: fill counter increments on each Enable cycle, 0..WINDOW-1. The oldest bit is the reset value 0, so cnt equals the ones received so far. On the Enable that brings the counter to WINDOW, go to RUN and set Valid=1 in the same registered update; Valid is high from the next cycle.
  - RUN: the fill counter holds (saturated), Valid stays 1.
  - Clear, or Reset, from any state returns to FILL with full reset values.
- Decision, per channel, evaluated on the updated count in the same registered update:
  - Evaluated only in RUN, including the cycle that enters RUN.
  - new cnt >= THR_HI -> Decision 1.
  - new cnt <= THR_LO -> Decision 0.
  - Otherwise Decision holds.
  - In FILL, Decision is held at 0.
- Simultaneous events:
  - Reset has priority over Clear, and Clear over Enable. A sample presented with Clear=1 is dropped.
  - Reset mid-window discards all partial history.
- Channels are fully independent apart from the shared FSM, Valid and Enable.

Test Plan:
All scenarios use SAMPLES=4, OSF=2 (WINDOW=8, CW=4), CHANNELS=2, THR_HI=6, THR_LO=2.
- Reset then 8 Enable cycles with DataIn=2'b01 -> ch0 count 1,2..8 one cycle after each edge, ch1 stays 0; Valid rises after the 8th sample; Decision=2'b01.
- Continue with 3 cycles of DataIn=2'b00 -> ch0 count 7,6,5; Decision[0] stays 1 at 6 and 5 (hold band). Then 3 more zeros -> 4,3,2; Decision[0] drops to 0 when the count reaches 2.
- In RUN, toggle Enable low for 5 cycles with DataIn changing -> counts, Decision and Valid unchanged.
- Alternating 1/0 stream on ch1 for 16 samples -> count settles at 4 after fill; Decision[1] stays 0 (never reaches 6).
- Assert Clear for 1 cycle mid-RUN together with Enable=1 and DataIn=2'b11 -> next cycle counts 0, Valid 0, Decision 0; the sample is dropped and the refill needs 8 new samples.
- All-ones stream for 20 samples, then assert Reset -> count saturates at 8 with no wrap; after Reset, all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/filtro_pb_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : filtro_pb_stream                                                |
// | Function : streaming multi-channel sliding-window ones counter with a      |
// |            hysteretic per-channel decision bit                             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module filtro_pb_stream #(
  parameter int SAMPLES  = 128,
  parameter int OSF      = 8,
  parameter int CHANNELS = 1,
  parameter int THR_HI   = (SAMPLES*OSF*3)/4,
  parameter int THR_LO   = (SAMPLES*OSF)/4
) (
  input  logic                                           P,
  input  logic                                           Reset,
  input  logic                                           Enable,
  input  logic                                           Clear,
  input  logic [CHANNELS-1:0]                            DataIn,
  output logic [CHANNELS*($clog2(SAMPLES*OSF)+1)-1:0]    DataOut,
  output logic [CHANNELS-1:0]                            Decision,
  output logic                                           Valid
);

  localparam int WINDOW = SAMPLES*OSF;
  localparam int CW     = $clog2(WINDOW) + 1;

  localparam logic [CW-1:0] C_WINDOW = CW'(WINDOW);
  localparam logic [CW-1:0] C_THR_HI = CW'(THR_HI);
  localparam logic [CW-1:0] C_THR_LO = CW'(THR_LO);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       fill_q, fill_d;
  logic                valid_q, valid_d;
  logic [CHANNELS-1:0] dec_q, dec_d;
  logic [WINDOW-1:0]   win_q [CHANNELS];
  logic [WINDOW-1:0]   win_d [CHANNELS];
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    dec_d   = dec_q;
    for (int c = 0; c < CHANNELS; c++) begin
      win_d[c] = win_q[c];
      cnt_d[c] = cnt_q[c];
    end

    if (Clear) begin
      state_d = S_FILL;
      fill_d  = '0;
      valid_d = 1'b0;
      dec_d   = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        win_d[c] = '0;
        cnt_d[c] = '0;
      end
    end else if (Enable) begin
      if (state_q == S_FILL) begin
        fill_d = fill_q + 1'b1;
        if (fill_d == C_WINDOW) begin
          state_d = S_RUN;
          valid_d = 1'b1;
        end
      end
      for (int c = 0; c < CHANNELS; c++) begin
        win_d[c] = {win_q[c][WINDOW-2:0], DataIn[c]};
        // Modular CW-bit arithmetic: the intermediate may exceed WINDOW but the result never does.
        cnt_d[c] = cnt_q[c] + CW'(DataIn[c]) - CW'(win_q[c][WINDOW-1]);
        if (state_d == S_RUN) begin
          if (cnt_d[c] >= C_THR_HI) begin
            dec_d[c] = 1'b1;
          end else if (cnt_d[c] <= C_THR_LO) begin
            dec_d[c] = 1'b0;
          end
        end else begin
          dec_d[c] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge P) begin
    if (Reset) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      valid_q <= 1'b0;
      dec_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        win_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      dec_q   <= dec_d;
      for (int c = 0; c < CHANNELS; c++) begin
        win_q[c] <= win_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign DataOut[c*CW +: CW] = cnt_q[c];
  end

  assign Decision = dec_q;
  assign Valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_filtro_pb_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_filtro_pb_stream                                             |
// | Function : self-checking bench for filtro_pb_stream against a queue model  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_filtro_pb_stream;

  localparam int SAMPLES  = 4;
  localparam int OSF      = 2;
  localparam int CHANNELS = 2;
  localparam int THR_HI   = 6;
  localparam int THR_LO   = 2;
  localparam int WINDOW   = SAMPLES*OSF;
  localparam int CW       = 4;

  logic                   P      = 1'b0;
  logic                   Reset  = 1'b0;
  logic                   Enable = 1'b0;
  logic                   Clear  = 1'b0;
  logic [CHANNELS-1:0]    DataIn = '0;
  logic [CHANNELS*CW-1:0] DataOut;
  logic [CHANNELS-1:0]    Decision;
  logic                   Valid;

  int n_total = 0;
  int n_bad   = 0;

  // Model: the last WINDOW accepted sample vectors, oldest at the front.
  logic [1:0] hist [$];
  logic [1:0] m_dec = 2'b00;

  always #5 P = ~P;

  filtro_pb_stream #(
    .SAMPLES (SAMPLES),
    .OSF     (OSF),
    .CHANNELS(CHANNELS),
    .THR_HI  (THR_HI),
    .THR_LO  (THR_LO)
  ) u_dut (
    .P       (P),
    .Reset   (Reset),
    .Enable  (Enable),
    .Clear   (Clear),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Decision(Decision),
    .Valid   (Valid)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_cnt(input int c);
    int s = 0;
    foreach (hist[i]) s += int'(hist[i][c]);
    return s;
  endfunction

  task automatic step(input logic rst, input logic clr, input logic en, input logic [1:0] din);
    @(negedge P);
    Reset  = rst;
    Clear  = clr;
    Enable = en;
    DataIn = din;
    @(posedge P);
    if (rst || clr) begin
      hist.delete();
      m_dec = 2'b00;
    end else if (en) begin
      hist.push_back(din);
      if (hist.size() > WINDOW) void'(hist.pop_front());
      for (int c = 0; c < CHANNELS; c++) begin
        if (hist.size() < WINDOW)       m_dec[c] = 1'b0;
        else if (m_cnt(c) >= THR_HI)    m_dec[c] = 1'b1;
        else if (m_cnt(c) <= THR_LO)    m_dec[c] = 1'b0;
      end
    end
    #1;
    check_val("cnt0",     32'(DataOut[CW-1:0]),    32'(m_cnt(0)));
    check_val("cnt1",     32'(DataOut[2*CW-1:CW]), 32'(m_cnt(1)));
    check_val("decision", 32'(Decision),           32'(m_dec));
    check_val("valid",    32'(Valid),              32'(hist.size() == WINDOW));
  endtask

  initial begin
    int bias;

    step(1'b1, 1'b0, 1'b0, 2'b11);
    check_val("reset_cnt", 32'(DataOut), 32'd0);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 2'b01);
    check_val("fill_cnt0", 32'(DataOut[CW-1:0]), 32'd8);
    check_val("fill_dec",  32'(Decision), 32'b01);
    check_val("fill_valid", 32'(Valid), 32'd1);

    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 2'b00);
    check_val("decay_cnt0", 32'(DataOut[CW-1:0]), 32'd2);
    check_val("decay_dec",  32'(Decision), 32'b00);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 2'($urandom));

    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, {1'(i % 2), 1'b0});
    check_val("alt_cnt1", 32'(DataOut[2*CW-1:CW]), 32'd4);

    step(1'b0, 1'b1, 1'b1, 2'b11);
    check_val("clear_valid", 32'(Valid), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 2'($urandom));
    check_val("refill_valid_7", 32'(Valid), 32'd0);
    step(1'b0, 1'b0, 1'b1, 2'($urandom));
    check_val("refill_valid_8", 32'(Valid), 32'd1);

    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 2'b11);
    check_val("sat_cnt", 32'(DataOut), 32'h88);
    step(1'b1, 1'b0, 1'b1, 2'b11);
    check_val("post_reset_all", 32'({DataOut, Decision, Valid}), 32'd0);

    // Randomized phases with a varying ones density so both thresholds get crossed.
    bias = 4;
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) bias = int'($urandom_range(0, 8));
      step(1'(($urandom % 101) == 0),
           1'(($urandom % 53) == 0),
           1'(($urandom % 4) != 0),
           {1'(int'($urandom % 8) < bias), 1'(int'($urandom % 8) < 8 - bias)});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
